sequence_bit_serializer: RTL

//  Parallel-to-serial front end for the bit-stream sequence detector: accepts WIDTH-bit words

---
 rtl/sequence_bit_serializer.sv | 77 +++++++
 1 files changed

// File: rtl/sequence_bit_serializer.sv
// Parallel-to-serial front end for the bit-stream sequence detector.
// Takes WIDTH-bit words over valid/ready and emits one bit per shift_en tick.
module sequence_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   word_in,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               shift_en,
  output logic               sequence_out,
  output logic               bit_valid,
  output logic               last_bit,
  output logic               busy,
  output logic [COUNT_W-1:0] words_sent
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             out_bit;

  assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign accept  = word_valid & word_ready;

  always_comb begin
    state_nxt    = state;
    word_ready   = 1'b0;
    busy         = 1'b0;
    sequence_out = 1'b0;
    bit_valid    = 1'b0;
    last_bit     = 1'b0;
    case (state)
      IDLE: begin
        word_ready = reset;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy         = 1'b1;
        sequence_out = out_bit;
        bit_valid    = shift_en;
        last_bit     = shift_en & (bit_cnt == LAST_IDX);
        // Ready only on the final-bit tick so a waiting word follows with no gap.
        word_ready   = reset & last_bit;
        if (last_bit && !accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg   <= word_in;
        bit_cnt <= '0;
      end else if (bit_valid) begin
        shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (last_bit) words_sent <= words_sent + 1'b1;
    end
  end
endmodule
